// File: rtl/wb_data_stage.sv
// wb_data_stage: writeback data select, load alignment/extension and registered RF write port.
// Define WB_FWD_EN to add the fwd1_* second-history forwarding registers.
module wb_data_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int PC_INC = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [5:0]        op,
    input  logic              reg_write,
    input  logic [4:0]        rd_in,
    input  logic [1:0]        byte_sel,
    input  logic [DATA_W-1:0] dmdout,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  wr_count
`ifdef WB_FWD_EN
    ,
    output logic              fwd1_we,
    output logic [4:0]        fwd1_wa,
    output logic [DATA_W-1:0] fwd1_wd
`endif
);
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LH  = 6'h21;

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       lo_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] sel_data;
    logic              misalign;

    // Sub-word loads always index within the low 32-bit word, even for DATA_W=64.
    assign lo_word = dmdout[31:0] >> {byte_sel, 3'b000};
    assign ld_byte = lo_word[7:0];
    assign ld_half = lo_word[15:0];

    assign misalign = (((op == OP_LH) || (op == OP_LHU)) && byte_sel[0]) ||
                      ((op == OP_LW) && (byte_sel != 2'd0));

    always_comb begin
        sel_data = (op == OP_LUI) ? {imm, {(DATA_W-IMM_W){1'b0}}} :
                   (op == OP_JAL) ? pc + DATA_W'(PC_INC) :
                   (op == OP_LW)  ? DATA_W'(dmdout[31:0]) :
                   (op == OP_LBU) ? DATA_W'(ld_byte) :
                   (op == OP_LB)  ? {{(DATA_W-8){ld_byte[7]}}, ld_byte} :
                   (op == OP_LHU) ? DATA_W'(ld_half) :
                   (op == OP_LH)  ? {{(DATA_W-16){ld_half[15]}}, ld_half} :
                                    aluout;
    end

    always_comb begin
        rf_we_d = rf_we_q;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            // The write leaving the stage is counted on the first non-stalled edge it is seen.
            cnt_d = cnt_q + CNT_W'(rf_we_q);
            if (flush) begin
                rf_we_d = 1'b0;
            end else begin
                rf_we_d = valid_in & reg_write & ~misalign & (rd_in != 5'd0);
                rf_wa_d = rd_in;
                rf_wd_d = sel_data;
                err_d   = err_q | (valid_in & misalign);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_wa        = rf_wa_q;
    assign rf_wd        = rf_wd_q;
    assign misalign_err = err_q;
    assign wr_count     = cnt_q;

`ifdef WB_FWD_EN
    logic              fwd_we_q;
    logic [4:0]        fwd_wa_q;
    logic [DATA_W-1:0] fwd_wd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_we_q <= 1'b0;
            fwd_wa_q <= '0;
            fwd_wd_q <= '0;
        end else if (!stall) begin
            fwd_we_q <= rf_we_q;
            fwd_wa_q <= rf_wa_q;
            fwd_wd_q <= rf_wd_q;
        end
    end

    assign fwd1_we = fwd_we_q;
    assign fwd1_wa = fwd_wa_q;
    assign fwd1_wd = fwd_wd_q;
`endif
endmodule

// File: tb/tb_wb_data_stage.sv
// tb_wb_data_stage: directed scoreboard bench for wb_data_stage (DATA_W=32, CNT_W=4).
// Covers WB_FWD_EN ports when the macro is defined.
module tb_wb_data_stage;
    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, stall = 1'b0, flush = 1'b0, reg_write = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [4:0]  rd_in = 5'd0;
    logic [1:0]  byte_sel = 2'd0;
    logic [31:0] dmdout = '0, aluout = '0, pc = '0;
    logic [15:0] imm = '0;
    logic        rf_we, misalign_err;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  wr_count;
`ifdef WB_FWD_EN
    logic        fwd1_we;
    logic [4:0]  fwd1_wa;
    logic [31:0] fwd1_wd;
`endif

    exp_t        sb[$];
    int          errors = 0, checks = 0;
    logic        m_we = 1'b0, exp_err = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic [3:0]  exp_cnt = '0;
    logic        f_we = 1'b0;
    logic [4:0]  f_wa = '0;
    logic [31:0] f_wd = '0;

    wb_data_stage #(.DATA_W(32), .IMM_W(16), .PC_INC(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .op(op), .reg_write(reg_write), .rd_in(rd_in), .byte_sel(byte_sel),
        .dmdout(dmdout), .aluout(aluout), .pc(pc), .imm(imm),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .misalign_err(misalign_err), .wr_count(wr_count)
`ifdef WB_FWD_EN
        , .fwd1_we(fwd1_we), .fwd1_wa(fwd1_wa), .fwd1_wd(fwd1_wd)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: queue the expected capture, advance, then pop and compare.
    task automatic cyc(input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
        exp_t e;
        if (!stall) begin
            exp_cnt = exp_cnt + 4'(m_we);
            f_we = m_we; f_wa = m_wa; f_wd = m_wd;
        end
        e.we = ewe; e.wa = ewa; e.wd = ewd;
        sb.push_back(e);
        m_we = ewe; m_wa = ewa; m_wd = ewd;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'(e.we));
            chk("rf_wa", 32'(rf_wa), 32'(e.wa));
            chk("rf_wd", rf_wd, e.wd);
        end
        chk("misalign_err", 32'(misalign_err), 32'(exp_err));
        chk("wr_count", 32'(wr_count), 32'(exp_cnt));
`ifdef WB_FWD_EN
        chk("fwd1_we", 32'(fwd1_we), 32'(f_we));
        chk("fwd1_wa", 32'(fwd1_wa), 32'(f_wa));
        chk("fwd1_wd", fwd1_wd, f_wd);
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_wa", 32'(rf_wa), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        chk("rst_cnt", 32'(wr_count), 32'd0);
`ifdef WB_FWD_EN
        chk("rst_fwd1_wd", fwd1_wd, 32'd0);
`endif
    endtask

    initial begin
        #12;
        check_reset_outputs();
        rst_n = 1'b1;
        valid_in = 1'b1; reg_write = 1'b1; rd_in = 5'd5; dmdout = 32'h80F1_7F82;
        op = 6'h20; byte_sel = 2'd0; cyc(1'b1, 5'd5, 32'hFFFF_FF82);
        op = 6'h24; byte_sel = 2'd1; cyc(1'b1, 5'd5, 32'h0000_007F);
        op = 6'h21; byte_sel = 2'd2; cyc(1'b1, 5'd5, 32'hFFFF_80F1);
        op = 6'h25; byte_sel = 2'd2; cyc(1'b1, 5'd5, 32'h0000_80F1);
        op = 6'h23; byte_sel = 2'd0; cyc(1'b1, 5'd5, 32'h80F1_7F82);
        op = 6'h03; pc = 32'h0040_0010; cyc(1'b1, 5'd5, 32'h0040_0014);
        op = 6'h0f; imm = 16'h1234; cyc(1'b1, 5'd5, 32'h1234_0000);
        op = 6'h03; pc = 32'hFFFF_FFFC; cyc(1'b1, 5'd5, 32'h0000_0000);
        op = 6'h00; aluout = 32'hDEAD_BEEF; rd_in = 5'd7; cyc(1'b1, 5'd7, 32'hDEAD_BEEF);
        rd_in = 5'd0; cyc(1'b0, 5'd0, 32'hDEAD_BEEF);
        // Misaligned word load: no write, sticky error.
        op = 6'h23; byte_sel = 2'd2; rd_in = 5'd5; exp_err = 1'b1;
        cyc(1'b0, 5'd5, 32'h80F1_7F82);
        op = 6'h21; byte_sel = 2'd1; cyc(1'b0, 5'd5, 32'hFFFF_F17F);
        op = 6'h00; byte_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            rd_in = 5'(i + 1); aluout = 32'(i * 3 + 1);
            cyc(1'b1, 5'(i + 1), 32'(i * 3 + 1));
        end
        // Stall holds everything; stall beats flush; flush alone drops the write.
        rd_in = 5'd9; aluout = 32'h0000_AAAA; cyc(1'b1, 5'd9, 32'h0000_AAAA);
        stall = 1'b1; rd_in = 5'd10; aluout = 32'h0000_5555;
        for (int i = 0; i < 3; i++) cyc(1'b1, 5'd9, 32'h0000_AAAA);
        flush = 1'b1; cyc(1'b1, 5'd9, 32'h0000_AAAA);
        stall = 1'b0; cyc(1'b0, 5'd9, 32'h0000_AAAA);
        flush = 1'b0; cyc(1'b1, 5'd10, 32'h0000_5555);
        // Asynchronous reset in mid-cycle.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0; exp_cnt = '0; exp_err = 1'b0;
        f_we = 1'b0; f_wa = '0; f_wd = '0;
        #2 rst_n = 1'b1;
        rd_in = 5'd3;
        for (int i = 0; i < 17; i++) begin
            aluout = 32'(100 + i);
            cyc(1'b1, 5'd3, 32'(100 + i));
        end
        valid_in = 1'b0; aluout = 32'h0000_0077; cyc(1'b0, 5'd3, 32'h0000_0077);
        chk("wrap_cnt", 32'(wr_count), 32'd1);
        valid_in = 1'b1; rd_in = 5'd0; cyc(1'b0, 5'd0, 32'h0000_0077);
        valid_in = 1'b0; cyc(1'b0, 5'd0, 32'h0000_0077);
        chk("rd0_cnt", 32'(wr_count), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_data_stage.md
Name: wb_data_stage

Overview:
- Parametrised writeback stage for the redirect pipeline: selects the register-file write data (ALU result, aligned and extended load data, link address, LUI immediate), registers it, and drives the RF write port one cycle later.
- Adds signed and unsigned byte/halfword loads, misalignment detection, stall/flush control, and a retired-write counter.
- Sits between the MEM stage outputs and the register file; its registered outputs also act as a forwarding source.

Parameters:
- DATA_W, 32, datapath width. Must be 32 or 64.
- IMM_W, 16, immediate width. Must be less than DATA_W.
- PC_INC, 4, link offset added to pc for jal.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  MEM-stage instruction valid.
- stall  in  1  hold all stage registers.
- flush  in  1  kill the instruction being captured.
- op  in  6  MIPS primary opcode.
- reg_write  in  1  control: instruction writes the RF.
- rd_in  in  5  destination register.
- byte_sel  in  2  low address bits of the load.
- dmdout  in  DATA_W  data-memory read word.
- aluout  in  DATA_W  ALU result.
- pc  in  DATA_W  instruction PC.
- imm  in  IMM_W  immediate field.
- rf_we  out  1  RF write enable (registered).
- rf_wa  out  5  RF write address (registered).
- rf_wd  out  DATA_W  RF write data (registered).
- misalign_err  out  1  sticky misaligned-load flag.
- wr_count  out  CNT_W  count of committed RF writes.

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_wa=0, rf_wd=0, misalign_err=0, wr_count=0. Reset mid-stall or mid-flush discards all state.
- Data select (combinational, op-decoded):
  - 0x0f lui: imm in the upper IMM_W bits, zeros below.
  - 0x03 jal: pc+PC_INC, modulo 2^DATA_W.
  - 0x23 lw: dmdout.
  - 0x24 lbu: byte (dmdout >> 8*byte_sel)[7:0], zero-extended.
  - 0x20 lb: same byte, sign-extended.
  - 0x25 lhu: halfword (dmdout >> 8*byte_sel)[15:0], zero-extended.
  - 0x21 lh: same halfword, sign-extended.
  - Any other op: aluout.
- Misalignment:
  - Condition: lh/lhu with byte_sel[0]=1, or lw with byte_sel≠0.
  - The write is suppressed: captured rf_we=0.
  - misalign_err sets on the capturing edge and stays set until reset.
- Capture rule, each rising edge:
  - stall=1: every register holds, including rf_we. stall has priority over flush.
  - stall=0 and flush=1: rf_we←0; rf_wa and rf_wd hold.
  - Otherwise: rf_we←valid_in & reg_write & ~misalign & (rd_in≠0); rf_wa←rd_in; rf_wd←selected data.
- Latency: exactly 1 cycle from the inputs to rf_*.
- rd_in=0: never writes, never counts.
- wr_count:
  - Increments on every edge where stall=0 and rf_we=1, i.e. each committed write is counted once, even while it is held by a stall.
  - Wraps from all-ones to 0.
- When DATA_W=64, lw zero-extends the selected 32-bit word; byte_sel still indexes within the low word.

Optional Feature:
- WB_FWD_EN defined: adds output ports fwd1_we, fwd1_wa, fwd1_wd.
  - These form a second-history register holding the previous rf_* values.
  - They update whenever stall=0, so EX can forward from two retired writes.
  - Reset value is 0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> all outputs 0 immediately, before the next clock edge.
- Loads: dmdout=0x80F1_7F82, valid_in=1, reg_write=1, rd=5, one cycle each:
  - lb sel=0 -> rf_wd=0xFFFF_FF82.
  - lbu sel=1 -> 0x0000_007F.
  - lh sel=2 -> 0xFFFF_80F1.
  - lhu sel=2 -> 0x0000_80F1.
  - Each appears one cycle after its inputs.
- Link and immediate: jal with pc=0x0040_0010 -> rf_wd=0x0040_0014. lui with imm=0x1234 -> 0x1234_0000. pc=0xFFFF_FFFC with jal -> 0x0000_0000.
- Misalignment: lw with sel=2 -> rf_we=0 and misalign_err=1, which stays 1 through 10 following valid writes. wr_count counts only the valid writes.
- Stall and flush: valid write captured, then stall=1 for 3 cycles -> rf_* constant and wr_count +1 only. stall=1 with flush=1 -> hold. flush=1 alone -> rf_we=0 next cycle.
- Counter wrap: CNT_W=4, 17 committed writes -> wr_count=1. A write to rd=0 -> no increment. With WB_FWD_EN: fwd1_wd equals the previous rf_wd.
